pwm_direction_decoder: RTL

Receive-side counterpart of the robot's motor PWM generator. Takes the left and right motor PWM lines and measures the high time of each over a fixed PWM period. It then classifies the pair back into the 2-bit direction code (00 stop, 01 forward, 10 turn left, 11 turn right) and reports a debounced direction. It sits on the feedback path between the motor driver outputs and the navigation logic, and is used both for closed-loop checking and as a loopback monitor in test.

---
 rtl/pwm_direction_decoder_if.sv | 37 +++
 rtl/pwm_direction_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pwm_direction_decoder_if.sv
// rtl/pwm_direction_decoder_if.sv - result bus from the PWM direction decoder to navigation logic
//
// Purpose: carries the measured duty counts, the confirmed direction code,
//          the window-complete pulse and the stuck-channel flag.
// Signals:
//   direction  [1:0]    confirmed direction code (00 stop, 01 fwd, 10 left, 11 right)
//   left_duty  [CW-1:0] left high-cycle count of the last completed window
//   right_duty [CW-1:0] right high-cycle count of the last completed window
//   win_valid           one-cycle pulse coincident with new duty values
//   fault               stuck-channel flag
// Modports: master (decoder, drives), slave (consumer, observes).

interface pwm_direction_decoder_if #(
    parameter int CW = 9
) ();
    logic [1:0]    direction;
    logic [CW-1:0] left_duty;
    logic [CW-1:0] right_duty;
    logic          win_valid;
    logic          fault;

    modport master (
        output direction,
        output left_duty,
        output right_duty,
        output win_valid,
        output fault
    );

    modport slave (
        input direction,
        input left_duty,
        input right_duty,
        input win_valid,
        input fault
    );
endinterface

// File: rtl/pwm_direction_decoder.sv
// rtl/pwm_direction_decoder.sv - measures left/right motor PWM duty and decodes a debounced direction
//
// Purpose: counts synchronized high cycles of each PWM line over a free-running
//          PERIOD-cycle window, latches the counts at window end, classifies them
//          into a 2-bit direction code and only reports a code after CONFIRM
//          consecutive identical classifications.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   left_pwm   in   left motor PWM (asynchronous to clk)
//   right_pwm  in   right motor PWM (asynchronous to clk)
//   dec        master modport of pwm_direction_decoder_if (direction, left_duty,
//              right_duty, win_valid, fault)
// Optional feature: define PWM_DECODE_FAULT_EN to build the stuck-channel
//          detector; otherwise fault is tied low.

module pwm_direction_decoder #(
    parameter int PERIOD   = 256,
    parameter int MIN_DUTY = 64,
    parameter int CONFIRM  = 2,
    parameter int CW       = $clog2(PERIOD + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          left_pwm,
    input  logic                          right_pwm,
    pwm_direction_decoder_if.master       dec
);

    localparam int WW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          left_s1_q, left_s2_q, right_s1_q, right_s2_q;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [CW-1:0] left_hi_q, left_hi_d, right_hi_q, right_hi_d;
    logic [CW-1:0] left_duty_q, left_duty_d, right_duty_q, right_duty_d;
    logic          win_valid_q, win_valid_d;
    logic [1:0]    cand_q, cand_d;
    logic [1:0]    direction_q, direction_d;
    logic [3:0]    conf_q, conf_d;
    logic          fault_q;

    logic          eow;
    logic [CW-1:0] left_sum, right_sum;
    logic          left_on, right_on;
    logic [1:0]    cls;

    always_comb begin
        eow = (win_cnt_q == WW'(PERIOD - 1));

        // Running count including this cycle's sample; held at PERIOD at most.
        left_sum  = (left_hi_q  >= CW'(PERIOD)) ? left_hi_q  : left_hi_q  + CW'(left_s2_q);
        right_sum = (right_hi_q >= CW'(PERIOD)) ? right_hi_q : right_hi_q + CW'(right_s2_q);

        win_cnt_d    = eow ? '0 : win_cnt_q + 1'b1;
        left_hi_d    = eow ? '0 : left_sum;
        right_hi_d   = eow ? '0 : right_sum;
        left_duty_d  = eow ? left_sum  : left_duty_q;
        right_duty_d = eow ? right_sum : right_duty_q;
        win_valid_d  = eow;

        // Classify the counts being latched this cycle so direction moves
        // together with win_valid.
        left_on  = (left_sum  >= CW'(MIN_DUTY));
        right_on = (right_sum >= CW'(MIN_DUTY));
        case ({left_on, right_on})
            2'b11:   cls = 2'b01;
            2'b01:   cls = 2'b10;
            2'b10:   cls = 2'b11;
            default: cls = 2'b00;
        endcase

        state_d     = state_q;
        cand_d      = cand_q;
        conf_d      = conf_q;
        direction_d = direction_q;
        if (eow) begin
            if (state_q == IDLE || cls != cand_q) begin
                cand_d  = cls;
                conf_d  = 4'd1;
                state_d = TRACK;
            end else if (conf_q < 4'(CONFIRM)) begin
                conf_d = conf_q + 1'b1;
            end
            // Covers CONFIRM == 1 as well: a fresh candidate is confirmed at once.
            if (conf_d == 4'(CONFIRM)) begin
                direction_d = cand_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_s1_q    <= 1'b0;
            left_s2_q    <= 1'b0;
            right_s1_q   <= 1'b0;
            right_s2_q   <= 1'b0;
            win_cnt_q    <= '0;
            left_hi_q    <= '0;
            right_hi_q   <= '0;
            left_duty_q  <= '0;
            right_duty_q <= '0;
            win_valid_q  <= 1'b0;
            state_q      <= IDLE;
            cand_q       <= 2'b00;
            conf_q       <= 4'd0;
            direction_q  <= 2'b00;
        end else begin
            left_s1_q    <= left_pwm;
            left_s2_q    <= left_s1_q;
            right_s1_q   <= right_pwm;
            right_s2_q   <= right_s1_q;
            win_cnt_q    <= win_cnt_d;
            left_hi_q    <= left_hi_d;
            right_hi_q   <= right_hi_d;
            left_duty_q  <= left_duty_d;
            right_duty_q <= right_duty_d;
            win_valid_q  <= win_valid_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            conf_q       <= conf_d;
            direction_q  <= direction_d;
        end
    end

`ifdef PWM_DECODE_FAULT_EN
    // Consecutive-window counters for "one side dead while the other drives".
    logic [2:0] lz_q, lz_d, rz_q, rz_d;
    logic       fault_d;

    always_comb begin
        lz_d    = lz_q;
        rz_d    = rz_q;
        fault_d = fault_q;
        if (eow) begin
            if (left_sum == '0 && right_on) begin
                lz_d = (lz_q == 3'd4) ? lz_q : lz_q + 1'b1;
            end else begin
                lz_d = 3'd0;
            end
            if (right_sum == '0 && left_on) begin
                rz_d = (rz_q == 3'd4) ? rz_q : rz_q + 1'b1;
            end else begin
                rz_d = 3'd0;
            end
            fault_d = (lz_d == 3'd4) || (rz_d == 3'd4) ||
                      (left_sum == CW'(PERIOD)) || (right_sum == CW'(PERIOD));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lz_q    <= 3'd0;
            rz_q    <= 3'd0;
            fault_q <= 1'b0;
        end else begin
            lz_q    <= lz_d;
            rz_q    <= rz_d;
            fault_q <= fault_d;
        end
    end
`else
    assign fault_q = 1'b0;
`endif

    assign dec.direction  = direction_q;
    assign dec.left_duty  = left_duty_q;
    assign dec.right_duty = right_duty_q;
    assign dec.win_valid  = win_valid_q;
    assign dec.fault      = fault_q;

endmodule
